// File: rtl/smart_viol_ctrl_if.sv
// smart_viol_ctrl_if: openMSP430 peripheral bus carrying register accesses to smart_viol_ctrl.
interface smart_viol_ctrl_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    modport master (output per_addr, per_din, per_en, per_we, input per_dout);
    modport slave (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/smart_viol_ctrl.sv
// smart_viol_ctrl: turns access violations into fixed-length core resets with a re-trigger guard and sticky records.
// Optional lock-out after LOCK_THRESH violations is enabled by defining SMART_VIOL_LOCK_EN.
module smart_viol_ctrl #(
    parameter int          RST_CYCLES   = 16,
    parameter int          GUARD_CYCLES = 4,
    parameter logic [14:0] BASE_ADDR    = 15'h0190,
    parameter int          LOCK_THRESH  = 3
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              viol_req,
    input  logic [15:0]       viol_addr,
    input  logic [15:0]       viol_pc,
    smart_viol_ctrl_if.slave  bus,
    output logic              smart_rst,
    output logic              viol_irq
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
`ifdef SMART_VIOL_LOCK_EN
        S_GUARD,
        S_LOCKED
`else
        S_GUARD
`endif
    } state_t;

    localparam logic [13:0] BASE_W = BASE_ADDR[14:1];

    state_t      state, state_nxt;
    logic [7:0]  tmr, tmr_nxt, cnt;
    logic        flag, ie, capture, locked, lock_nxt;
    logic [15:0] addr_r, pc_r;
    logic [13:0] off;
    logic        hit, wr, wr_lo, cnt_clr, rd;

    assign off     = bus.per_addr - BASE_W;
    assign hit     = off < 14'd3;
    assign wr      = bus.per_en & hit & (off == 14'd0) & |bus.per_we;
    assign wr_lo   = wr & bus.per_we[0];
    assign cnt_clr = wr & bus.per_we[1] & bus.per_din[15];
    assign rd      = bus.per_en & hit & (bus.per_we == 2'b00);

`ifdef SMART_VIOL_LOCK_EN
    assign locked   = state == S_LOCKED;
    assign lock_nxt = state_nxt == S_LOCKED;
`else
    assign locked   = 1'b0;
    assign lock_nxt = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr + 8'd1;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                tmr_nxt = '0;
                if (viol_req) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: if (tmr == 8'(RST_CYCLES - 1)) begin
                tmr_nxt   = '0;
                state_nxt = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;
`ifdef SMART_VIOL_LOCK_EN
                if (cnt >= 8'(LOCK_THRESH)) state_nxt = S_LOCKED;
`endif
            end
            S_GUARD: if (tmr == 8'(GUARD_CYCLES - 1)) begin
                tmr_nxt   = '0;
                state_nxt = S_IDLE;
            end
            default: begin
                tmr_nxt   = '0;
                state_nxt = locked ? state : S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            tmr       <= '0;
            smart_rst <= 1'b0;
            viol_irq  <= 1'b0;
            flag      <= 1'b0;
            ie        <= 1'b0;
            cnt       <= '0;
            addr_r    <= '0;
            pc_r      <= '0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            smart_rst <= (state_nxt == S_HOLD) | lock_nxt;
            viol_irq  <= flag & ie;
            // a capture beats a same-cycle W1C, and beats a same-cycle CNT clear (leaving 1)
            flag      <= capture | (flag & ~(wr_lo & bus.per_din[0]));
            if (wr_lo) ie <= bus.per_din[1];
            cnt       <= cnt_clr ? {7'd0, capture} : (capture && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
            if (capture) begin
                addr_r <= viol_addr;
                pc_r   <= viol_pc;
            end
        end
    end

    assign bus.per_dout = !rd ? 16'h0000 :
                          (off == 14'd0) ? {cnt, 5'd0, locked, ie, flag} :
                          (off == 14'd1) ? addr_r : pc_r;
endmodule

// File: tb/tb_smart_viol_ctrl.sv
// tb_smart_viol_ctrl: directed self-checking bench for smart_viol_ctrl (default parameters).
module tb_smart_viol_ctrl;
    logic        mclk = 1'b0, reset_n = 1'b0, viol_req = 1'b0;
    logic [15:0] viol_addr = '0, viol_pc = '0;
    logic        smart_rst, viol_irq;
    logic [15:0] d;
    int          passed = 0, total = 0;

    localparam logic [13:0] A_ST = 14'h00C8, A_AD = 14'h00C9, A_PC = 14'h00CA;

    smart_viol_ctrl_if bus();

    smart_viol_ctrl dut (
        .mclk(mclk), .reset_n(reset_n), .viol_req(viol_req), .viol_addr(viol_addr),
        .viol_pc(viol_pc), .bus(bus), .smart_rst(smart_rst), .viol_irq(viol_irq)
    );

    always #5 mclk = ~mclk;

    task automatic rd(input logic [13:0] a, output logic [15:0] v);
        bus.per_addr = a; bus.per_we = 2'b00; bus.per_en = 1'b1;
        #1 v = bus.per_dout;
        bus.per_en = 1'b0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [1:0] we, input logic [15:0] v);
        bus.per_addr = a; bus.per_we = we; bus.per_din = v; bus.per_en = 1'b1;
        @(negedge mclk);
        bus.per_en = 1'b0; bus.per_we = 2'b00;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge mclk);
        reset_n = 1'b1;
        @(negedge mclk);
    endtask

    task automatic pulse(input logic [15:0] a, input logic [15:0] p);
        viol_addr = a; viol_pc = p; viol_req = 1'b1;
        @(negedge mclk);
        viol_req = 1'b0;
        repeat (24) @(negedge mclk);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (smart_rst !== 1'b0) $display("FAIL reset_smart_rst got %b exp 0", smart_rst); else passed++;
        total++; if (viol_irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", viol_irq); else passed++;
        rd(A_ST, d); total++; if (d !== 16'h0000) $display("FAIL reset_status got %h exp 0000", d); else passed++;
        viol_addr = 16'h1234; viol_pc = 16'h5678; viol_req = 1'b1;
        @(negedge mclk); viol_req = 1'b0;
        repeat (5) @(negedge mclk);
        total++; if (smart_rst !== 1'b1) $display("FAIL reset_mid_hold got %b exp 1", smart_rst); else passed++;
        #2 reset_n = 1'b0;
        #1 total++; if (smart_rst !== 1'b0) $display("FAIL reset_async_drop got %b exp 0", smart_rst); else passed++;
        @(negedge mclk); reset_n = 1'b1;
        @(negedge mclk);
        rd(A_ST, d); total++; if (d !== 16'h0000) $display("FAIL reset_status_after got %h exp 0000", d); else passed++;
        rd(A_AD, d); total++; if (d !== 16'h0000) $display("FAIL reset_addr got %h exp 0000", d); else passed++;
        rd(A_PC, d); total++; if (d !== 16'h0000) $display("FAIL reset_pc got %h exp 0000", d); else passed++;
    endtask

    task automatic test_single();
        int hi = 0, first = -1;
        viol_addr = 16'h0200; viol_pc = 16'hE010; viol_req = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge mclk);
            if (i == 2) viol_req = 1'b0;
            if (smart_rst) begin hi++; if (first < 0) first = i; end
        end
        total++; if (hi != 16) $display("FAIL single_pulse_len got %0d exp 16", hi); else passed++;
        total++; if (first != 0) $display("FAIL single_pulse_start got %0d exp 0", first); else passed++;
        rd(A_ST, d); total++; if (d !== 16'h0101) $display("FAIL single_status got %h exp 0101", d); else passed++;
        rd(A_AD, d); total++; if (d !== 16'h0200) $display("FAIL single_addr got %h exp 0200", d); else passed++;
        rd(A_PC, d); total++; if (d !== 16'hE010) $display("FAIL single_pc got %h exp e010", d); else passed++;
    endtask

    task automatic test_guard();
        int hi = 0;
        do_reset();
        viol_addr = 16'h0200; viol_pc = 16'h1111; viol_req = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            @(negedge mclk);
            if (i == 0) viol_req = 1'b0;
            if (i == 3) begin viol_req = 1'b1; viol_addr = 16'h0300; viol_pc = 16'h2222; end
            if (i == 19) viol_req = 1'b0;
            if (smart_rst) hi++;
        end
        total++; if (hi != 16) $display("FAIL guard_no_retrigger got %0d exp 16", hi); else passed++;
        rd(A_ST, d); total++; if (d !== 16'h0101) $display("FAIL guard_status got %h exp 0101", d); else passed++;
        rd(A_AD, d); total++; if (d !== 16'h0200) $display("FAIL guard_addr got %h exp 0200", d); else passed++;
        rd(A_PC, d); total++; if (d !== 16'h1111) $display("FAIL guard_pc got %h exp 1111", d); else passed++;
        viol_req = 1'b1;
        @(negedge mclk); viol_req = 1'b0;
        total++; if (smart_rst !== 1'b1) $display("FAIL guard_new_pulse got %b exp 1", smart_rst); else passed++;
        rd(A_ST, d); total++; if (d !== 16'h0201) $display("FAIL guard_status2 got %h exp 0201", d); else passed++;
        rd(A_AD, d); total++; if (d !== 16'h0300) $display("FAIL guard_addr2 got %h exp 0300", d); else passed++;
        repeat (24) @(negedge mclk);
    endtask

    task automatic test_bus();
        wr(A_ST, 2'b01, 16'h0002);
        total++; if (viol_irq !== 1'b0) $display("FAIL bus_irq_delay got %b exp 0", viol_irq); else passed++;
        @(negedge mclk);
        total++; if (viol_irq !== 1'b1) $display("FAIL bus_irq_set got %b exp 1", viol_irq); else passed++;
        wr(A_ST, 2'b01, 16'h0003);
        total++; if (viol_irq !== 1'b1) $display("FAIL bus_irq_hold got %b exp 1", viol_irq); else passed++;
        @(negedge mclk);
        total++; if (viol_irq !== 1'b0) $display("FAIL bus_irq_clear got %b exp 0", viol_irq); else passed++;
        rd(A_ST, d); total++; if (d !== 16'h0202) $display("FAIL bus_w1c_status got %h exp 0202", d); else passed++;
        wr(A_ST, 2'b01, 16'h8002);
        rd(A_ST, d); total++; if (d !== 16'h0202) $display("FAIL bus_lo_no_clear got %h exp 0202", d); else passed++;
        wr(A_ST, 2'b11, 16'h8002);
        rd(A_ST, d); total++; if (d !== 16'h0002) $display("FAIL bus_cnt_clear got %h exp 0002", d); else passed++;
        wr(A_AD, 2'b11, 16'hFFFF);
        rd(A_AD, d); total++; if (d !== 16'h0300) $display("FAIL bus_addr_ro got %h exp 0300", d); else passed++;
        bus.per_addr = A_AD; bus.per_we = 2'b01; bus.per_en = 1'b1;
        #1 total++; if (bus.per_dout !== 16'h0000) $display("FAIL bus_dout_on_write got %h exp 0000", bus.per_dout); else passed++;
        bus.per_en = 1'b0; bus.per_we = 2'b00;
        rd(14'h00CB, d); total++; if (d !== 16'h0000) $display("FAIL bus_above_range got %h exp 0000", d); else passed++;
        rd(14'h00C7, d); total++; if (d !== 16'h0000) $display("FAIL bus_below_range got %h exp 0000", d); else passed++;
        @(negedge mclk);
    endtask

    task automatic test_collide();
        viol_addr = 16'h0400; viol_pc = 16'h4444; viol_req = 1'b1;
        wr(A_ST, 2'b11, 16'h8003);
        viol_req = 1'b0;
        rd(A_ST, d); total++; if (d !== 16'h0103) $display("FAIL collide_status got %h exp 0103", d); else passed++;
        repeat (24) @(negedge mclk);
    endtask

`ifdef SMART_VIOL_LOCK_EN
    task automatic test_lock();
        do_reset();
        repeat (3) pulse(16'h0500, 16'h5555);
        repeat (40) @(negedge mclk);
        total++; if (smart_rst !== 1'b1) $display("FAIL lock_rst got %b exp 1", smart_rst); else passed++;
        rd(A_ST, d); total++; if (d !== 16'h0305) $display("FAIL lock_status got %h exp 0305", d); else passed++;
        wr(A_ST, 2'b11, 16'h8000);
        repeat (30) @(negedge mclk);
        total++; if (smart_rst !== 1'b1) $display("FAIL lock_after_clear got %b exp 1", smart_rst); else passed++;
        rd(A_ST, d); total++; if (d !== 16'h0005) $display("FAIL lock_status_clr got %h exp 0005", d); else passed++;
        do_reset();
        total++; if (smart_rst !== 1'b0) $display("FAIL lock_reset got %b exp 0", smart_rst); else passed++;
        rd(A_ST, d); total++; if (d !== 16'h0000) $display("FAIL lock_reset_status got %h exp 0000", d); else passed++;
    endtask
`else
    task automatic test_saturation();
        do_reset();
        repeat (260) pulse(16'h0600, 16'h6666);
        rd(A_ST, d); total++; if (d !== 16'hFF01) $display("FAIL sat_status got %h exp ff01", d); else passed++;
        total++; if (smart_rst !== 1'b0) $display("FAIL sat_rst_idle got %b exp 0", smart_rst); else passed++;
    endtask
`endif

    initial begin
        bus.per_addr = '0; bus.per_din = '0; bus.per_en = 1'b0; bus.per_we = 2'b00;
        @(negedge mclk);
        test_reset();
        test_single();
        test_guard();
        test_bus();
        test_collide();
`ifdef SMART_VIOL_LOCK_EN
        test_lock();
`else
        test_saturation();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/smart_viol_ctrl.md
Name: smart_viol_ctrl

Overview:
- Sits directly downstream of the memory-access controller. Consumes its one-cycle-latched violation request (`reset` output) plus the offending data address and PC.
- Turns each violation into a clean, fixed-length core reset pulse, then masks re-triggers during a guard window.
- Keeps sticky violation records across core resets, readable over the openMSP430 peripheral bus.

Parameters:
- RST_CYCLES, 16: length of the `smart_rst` pulse in mclk cycles (1..255).
- GUARD_CYCLES, 4: cycles after release during which `viol_req` is ignored (0..255).
- BASE_ADDR, 15'h0190: byte base address of the register block. Word-aligned. Occupies 3 words.
- LOCK_THRESH, 3: violation count that triggers lock-out (only with SMART_VIOL_LOCK_EN).

Ports:
- mclk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset. Sole clear source for all state in this block.
- viol_req  in  1  violation request from the access controller. Level; may stay high several cycles.
- viol_addr  in  16  data address presented with `viol_req`.
- viol_pc  in  16  instruction address presented with `viol_req`.
- per_addr  in  14  peripheral word address.
- per_din  in  16  peripheral write data.
- per_en  in  1  peripheral access strobe.
- per_we  in  2  byte write enables.
- smart_rst  out  1  active-high reset to the CPU core.
- viol_irq  out  1  level interrupt: sticky flag set and IE=1.
- per_dout  out  16  read data. 0 when not selected.

Behaviour:
- Reset values (reset_n low): FSM=IDLE, counters=0, smart_rst=0, viol_irq=0, all registers=0, per_dout=0.
- States:
  - IDLE: on `viol_req`=1, capture viol_addr/viol_pc into ADDR/PC, set STATUS.FLAG and increment STATUS.CNT, then go to HOLD. `smart_rst` rises on the next edge, one cycle after the sampled `viol_req`.
  - HOLD: `smart_rst`=1 for exactly RST_CYCLES cycles. `viol_req` is ignored; no capture, no count. Then go to GUARD.
  - GUARD: `smart_rst`=0 for GUARD_CYCLES cycles with `viol_req` ignored, then go to IDLE. If GUARD_CYCLES=0, go HOLD→IDLE directly.
- Captures happen only on the IDLE transition. Each pulse records the first violation only.
- STATUS.CNT[7:0] saturates at 255 and never wraps.
- Registers are cleared only by reset_n. `smart_rst` does not affect them.
- Register map (word offset from BASE_ADDR):
  - 0 STATUS: [0] FLAG (W1C), [1] IE (R/W), [2] LOCKED (RO), [15:8] CNT (RO). Writing bit 15=1 clears CNT.
  - 1 ADDR: RO.
  - 2 PC: RO.
- Writes honour per_we: byte 0 = per_we[0], byte 1 = per_we[1].
- Read: `per_dout` is valid combinationally when per_en=1, per_we=0 and the address hits the block. Otherwise `per_dout`=0.
- Simultaneous capture and FLAG W1C in the same cycle: the set wins.
- Simultaneous CNT increment and CNT clear: the result is 1.
- `viol_irq` = FLAG & IE, registered (one-cycle delay).

Optional Feature:
- Macro: SMART_VIOL_LOCK_EN.
- With the macro defined:
  - When CNT reaches LOCK_THRESH at the end of HOLD, the FSM enters LOCKED instead of GUARD.
  - In LOCKED, `smart_rst`=1 permanently and STATUS.LOCKED=1.
  - Only reset_n exits LOCKED. Bus writes still work, but clearing CNT does not unlock.
- Without the macro: there is no LOCKED state, STATUS[2] reads 0, and LOCK_THRESH is unused.

Test Plan:
- Reset: reset_n low mid-HOLD → `smart_rst` drops asynchronously; all registers read 0 after release.
- Single violation: `viol_req` high 3 cycles with addr=16'h0200, pc=16'hE010 →
  - `smart_rst` high exactly 16 cycles starting 1 cycle later;
  - STATUS=16'h0101; ADDR=0200; PC=E010.
- Guard masking: second `viol_req` with addr=16'h0300 during HOLD and during GUARD → CNT stays 1 and ADDR stays 0200. A request 1 cycle after GUARD ends → new pulse, CNT=2, ADDR=0300.
- Bus:
  - write IE=1 → viol_irq=1;
  - W1C FLAG → viol_irq falls next cycle;
  - write bit15 → CNT=0;
  - per_we=2'b01 does not change CNT clear.
- Saturation: 260 violations → CNT reads 255.
- With SMART_VIOL_LOCK_EN: 3 violations → `smart_rst` stays high indefinitely, STATUS[2]=1. Only reset_n clears it.
